// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller: ld_st size codes,
// controller states and the alignment rule used by the error decoder.
package dmem_access_ctrl_pkg;

    localparam logic [1:0] SZ_NONE = 2'd0;
    localparam logic [1:0] SZ_B    = 2'd1;
    localparam logic [1:0] SZ_H    = 2'd2;
    localparam logic [1:0] SZ_W    = 2'd3;
    localparam int         UNS_BIT = 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    // Byte accesses are always aligned; halves need lsb[0]=0, words need lsb=0.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
        case (size)
            SZ_H:    return lsb[0];
            SZ_W:    return lsb != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Memory-side bus of the access controller: request strobe, word address,
// byte-lane enables and data out; completion and read data back.
interface dmem_access_ctrl_if #(
    parameter int ADDR_W = 32
) ();

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_we;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_addr, mem_we, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_addr, mem_we, mem_wdata,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/dmem_align_chk.sv
// Combinational access-legality check: misaligned halfword/word, or a request
// that asks for both a store and a load at once.
module dmem_align_chk
    import dmem_access_ctrl_pkg::*;
(
    input  logic [1:0] st_size,
    input  logic [1:0] ld_size,
    input  logic [1:0] lsb,
    output logic       err
);

    assign err = misaligned(st_size, lsb)
               | misaligned(ld_size, lsb)
               | ((st_size != SZ_NONE) && (ld_size != SZ_NONE));

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: one outstanding req/ack transaction, pipeline
// stall while in flight. Define DMEM_TIMEOUT_EN to abort REQ after TIMEOUT_CYCLES.
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [4:0]         ld_st,
    input  logic [ADDR_W-1:0]  daddr,
    input  logic [3:0]         we_in,
    input  logic [31:0]        dwdata_in,
    dmem_access_ctrl_if.master mem,
    output logic [31:0]        drdata,
    output logic               rsp_valid,
    output logic               stall,
    output logic               acc_err
);

    state_t            state, state_n;
    logic [1:0]        ld_size_q, ld_size_n;
    logic              mem_req_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [3:0]        mem_we_n;
    logic [31:0]       mem_wdata_n;
    logic [31:0]       drdata_n;
    logic              rsp_valid_n;
    logic              acc_err_n;
    logic              accept;
    logic              align_err;
    logic              uns_unused;

    dmem_align_chk u_align_chk (
        .st_size (ld_st[1:0]),
        .ld_size (ld_st[3:2]),
        .lsb     (daddr[1:0]),
        .err     (align_err)
    );

    // Signedness only matters to the shifter's load extraction, not here.
    assign uns_unused = ld_st[UNS_BIT];

    assign req_ready = (state != REQ);
    assign accept    = req_valid && req_ready;
    assign stall     = (state == REQ);

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt, wait_cnt_n;
    logic             timeout;
    assign timeout = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    localparam int timeout_unused = TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_n     = state;
        ld_size_n   = ld_size_q;
        mem_req_n   = mem.mem_req;
        mem_addr_n  = mem.mem_addr;
        mem_we_n    = mem.mem_we;
        mem_wdata_n = mem.mem_wdata;
        drdata_n    = drdata;
        acc_err_n   = acc_err;
        rsp_valid_n = 1'b0;
`ifdef DMEM_TIMEOUT_EN
        wait_cnt_n  = wait_cnt;
`endif
        case (state)
            REQ: begin
                if (mem.mem_ack) begin
                    state_n     = RESP;
                    mem_req_n   = 1'b0;
                    mem_we_n    = 4'h0;
                    drdata_n    = (ld_size_q != SZ_NONE) ? mem.mem_rdata : 32'h0;
                    acc_err_n   = 1'b0;
                    rsp_valid_n = 1'b1;
                end
`ifdef DMEM_TIMEOUT_EN
                else if (timeout) begin
                    state_n     = RESP;
                    mem_req_n   = 1'b0;
                    mem_we_n    = 4'h0;
                    drdata_n    = 32'h0;
                    acc_err_n   = 1'b1;
                    rsp_valid_n = 1'b1;
                end else begin
                    wait_cnt_n = wait_cnt + 1'b1;
                end
`endif
            end
            // IDLE and RESP both accept; RESP falls back to IDLE when nothing arrives.
            default: begin
                state_n = IDLE;
                if (accept) begin
                    ld_size_n   = ld_st[3:2];
                    mem_addr_n  = {daddr[ADDR_W-1:2], 2'b00};
                    mem_we_n    = (ld_st[1:0] != SZ_NONE) ? we_in : 4'h0;
                    mem_wdata_n = dwdata_in;
                    if (align_err || (ld_st[3:0] == 4'h0)) begin
                        state_n     = RESP;
                        drdata_n    = 32'h0;
                        acc_err_n   = align_err;
                        rsp_valid_n = 1'b1;
                    end else begin
                        state_n   = REQ;
                        mem_req_n = 1'b1;
`ifdef DMEM_TIMEOUT_EN
                        wait_cnt_n = '0;
`endif
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            ld_size_q     <= SZ_NONE;
            mem.mem_req   <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_we    <= 4'h0;
            mem.mem_wdata <= 32'h0;
            drdata        <= 32'h0;
            rsp_valid     <= 1'b0;
            acc_err       <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
            wait_cnt      <= '0;
`endif
        end else begin
            state         <= state_n;
            ld_size_q     <= ld_size_n;
            mem.mem_req   <= mem_req_n;
            mem.mem_addr  <= mem_addr_n;
            mem.mem_we    <= mem_we_n;
            mem.mem_wdata <= mem_wdata_n;
            drdata        <= drdata_n;
            rsp_valid     <= rsp_valid_n;
            acc_err       <= acc_err_n;
`ifdef DMEM_TIMEOUT_EN
            wait_cnt      <= wait_cnt_n;
`endif
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed vector table, reset-in-REQ
// sequence, randomized transactions against a size/alignment reference model.
module tb_dmem_access_ctrl;

    typedef struct {
        logic [4:0]  ld_st;
        logic [31:0] daddr;
        logic [3:0]  we;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] rdata;
        logic        exp_err;
        logic        exp_mem;
        logic [31:0] exp_addr;
        logic [3:0]  exp_we;
        logic [31:0] exp_dr;
    } txn_t;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  ld_st;
    logic [31:0] daddr;
    logic [3:0]  we_in;
    logic [31:0] dwdata_in;
    logic [31:0] drdata;
    logic        rsp_valid;
    logic        stall;
    logic        acc_err;

    int          checks;
    int          errors;
    logic [31:0] last_dr;
    logic        last_err;
    txn_t        vecs[12];

    dmem_access_ctrl_if #(.ADDR_W(32)) mem_bus ();

    dmem_access_ctrl #(
        .TIMEOUT_CYCLES (4),
        .ADDR_W         (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .ld_st     (ld_st),
        .daddr     (daddr),
        .we_in     (we_in),
        .dwdata_in (dwdata_in),
        .mem       (mem_bus),
        .drdata    (drdata),
        .rsp_valid (rsp_valid),
        .stall     (stall),
        .acc_err   (acc_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    function automatic int sizeBytes(input logic [1:0] code);
        case (code)
            2'd1:    return 1;
            2'd2:    return 2;
            2'd3:    return 4;
            default: return 0;
        endcase
    endfunction

    // Reference model: access legality and memory-side results from sizes in bytes.
    function automatic txn_t makeTxn(input logic [4:0] ls, input logic [31:0] a, input logic [3:0] we,
                                     input logic [31:0] wd, input int dly, input logic [31:0] rd);
        txn_t t;
        int   st_b;
        int   ld_b;
        st_b = sizeBytes(ls[1:0]);
        ld_b = sizeBytes(ls[3:2]);
        t.ld_st    = ls;
        t.daddr    = a;
        t.we       = we;
        t.wdata    = wd;
        t.delay    = dly;
        t.rdata    = rd;
        t.exp_err  = (st_b != 0 && ld_b != 0) || (st_b != 0 && (a % st_b) != 0)
                   || (ld_b != 0 && (a % ld_b) != 0);
        t.exp_mem  = !t.exp_err && (st_b + ld_b != 0);
        t.exp_addr = a - (a % 4);
        t.exp_we   = (st_b != 0) ? we : 4'h0;
        t.exp_dr   = (t.exp_mem && ld_b != 0) ? rd : 32'h0;
        return t;
    endfunction

    // Presents one request at a negedge and follows it through to its response.
    task automatic applyStimulus(input txn_t t, input string tag);
        req_valid = 1'b1;
        ld_st     = t.ld_st;
        daddr     = t.daddr;
        we_in     = t.we;
        dwdata_in = t.wdata;
        mem_bus.mem_ack = 1'b0;
        checkOutput({tag, " ready"}, 32'(req_ready), 32'd1);
        checkOutput({tag, " req_at_accept"}, 32'(mem_bus.mem_req), 32'd0);
        checkOutput({tag, " stall_at_accept"}, 32'(stall), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        if (t.exp_mem) begin
            for (int i = 0; i <= t.delay; i++) begin
                checkOutput({tag, " mem_req"}, 32'(mem_bus.mem_req), 32'd1);
                checkOutput({tag, " stall"}, 32'(stall), 32'd1);
                checkOutput({tag, " busy_ready"}, 32'(req_ready), 32'd0);
                checkOutput({tag, " mem_addr"}, mem_bus.mem_addr, t.exp_addr);
                checkOutput({tag, " mem_we"}, 32'(mem_bus.mem_we), 32'(t.exp_we));
                checkOutput({tag, " mem_wdata"}, mem_bus.mem_wdata, t.wdata);
                checkOutput({tag, " early_rsp"}, 32'(rsp_valid), 32'd0);
                mem_bus.mem_ack   = (i == t.delay);
                mem_bus.mem_rdata = (i == t.delay) ? t.rdata : $urandom;
                @(negedge clk);
            end
            mem_bus.mem_ack = 1'b0;
            checkOutput({tag, " we_dropped"}, 32'(mem_bus.mem_we), 32'd0);
        end
        checkOutput({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        checkOutput({tag, " acc_err"}, 32'(acc_err), 32'(t.exp_err));
        checkOutput({tag, " drdata"}, drdata, t.exp_dr);
        checkOutput({tag, " req_done"}, 32'(mem_bus.mem_req), 32'd0);
        checkOutput({tag, " stall_done"}, 32'(stall), 32'd0);
        checkOutput({tag, " resp_ready"}, 32'(req_ready), 32'd1);
        last_dr  = t.exp_dr;
        last_err = t.exp_err;
    endtask

    // Idle cycles with stray acks; response fields must hold and memory stays quiet.
    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            mem_bus.mem_ack   = 1'($urandom_range(0, 1));
            mem_bus.mem_rdata = $urandom;
            @(negedge clk);
            mem_bus.mem_ack = 1'b0;
            checkOutput("idle rsp_valid", 32'(rsp_valid), 32'd0);
            checkOutput("idle mem_req", 32'(mem_bus.mem_req), 32'd0);
            checkOutput("idle drdata", drdata, last_dr);
            checkOutput("idle acc_err", 32'(acc_err), 32'(last_err));
            checkOutput("idle ready", 32'(req_ready), 32'd1);
        end
    endtask

    initial begin
        logic [1:0] st;
        logic [1:0] ld;
        txn_t       t;

        checks    = 0;
        errors    = 0;
        last_dr   = 32'h0;
        last_err  = 1'b0;
        clk       = 1'b0;
        reset     = 1'b1;
        req_valid = 1'b0;
        ld_st     = 5'h0;
        daddr     = 32'h0;
        we_in     = 4'h0;
        dwdata_in = 32'h0;
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = 32'h0;

        //          ld_st     daddr         we    wdata         dly rdata         err   mem   addr          we    drdata
        vecs[0]  = '{5'b01100, 32'h0000_0100, 4'h0, 32'h0000_0000, 3, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0000_0100, 4'h0, 32'hDEAD_BEEF};
        vecs[1]  = '{5'b01000, 32'h0000_0101, 4'h0, 32'h0000_0000, 0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0100, 4'h0, 32'h0000_0000};
        vecs[2]  = '{5'b00001, 32'h0000_0203, 4'h8, 32'hAB00_0000, 0, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_0200, 4'h8, 32'h0000_0000};
        vecs[3]  = '{5'b00011, 32'h0000_0102, 4'hF, 32'h1111_1111, 0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0100, 4'hF, 32'h0000_0000};
        vecs[4]  = '{5'b00100, 32'h0000_0007, 4'h0, 32'h0000_0000, 1, 32'h1122_3344, 1'b0, 1'b1, 32'h0000_0004, 4'h0, 32'h1122_3344};
        vecs[5]  = '{5'b10000, 32'h0000_0055, 4'h0, 32'h0000_0000, 0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0054, 4'h0, 32'h0000_0000};
        vecs[6]  = '{5'b11000, 32'h0000_0012, 4'h0, 32'h0000_0000, 2, 32'hCAFE_F00D, 1'b0, 1'b1, 32'h0000_0010, 4'h0, 32'hCAFE_F00D};
        vecs[7]  = '{5'b00101, 32'h0000_0040, 4'h1, 32'h0000_00AA, 0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0040, 4'h1, 32'h0000_0000};
        vecs[8]  = '{5'b00010, 32'h0000_0202, 4'hC, 32'hBEEF_0000, 0, 32'h5555_AAAA, 1'b0, 1'b1, 32'h0000_0200, 4'hC, 32'h0000_0000};
        vecs[9]  = '{5'b00010, 32'h0000_0203, 4'hC, 32'hBEEF_0000, 0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0200, 4'hC, 32'h0000_0000};
        vecs[10] = '{5'b00011, 32'hFFFF_FFFC, 4'hF, 32'h0102_0304, 2, 32'h0000_0000, 1'b0, 1'b1, 32'hFFFF_FFFC, 4'hF, 32'h0000_0000};
        vecs[11] = '{5'b01100, 32'h0000_1003, 4'h0, 32'h0000_0000, 0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_1000, 4'h0, 32'h0000_0000};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkOutput("reset mem_req", 32'(mem_bus.mem_req), 32'd0);
        checkOutput("reset mem_addr", mem_bus.mem_addr, 32'd0);
        checkOutput("reset mem_we", 32'(mem_bus.mem_we), 32'd0);
        checkOutput("reset mem_wdata", mem_bus.mem_wdata, 32'd0);
        checkOutput("reset drdata", drdata, 32'd0);
        checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset acc_err", 32'(acc_err), 32'd0);
        checkOutput("reset ready", 32'(req_ready), 32'd1);
        checkOutput("reset stall", 32'(stall), 32'd0);

        // First half back-to-back (accepted in RESP), later entries with stray-ack gaps.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
            idleCycles((i >= 6 && i % 2 == 1) ? 1 : 0);
        end
        idleCycles(2);

        // Reset while REQ is outstanding, followed by a late ack.
        req_valid = 1'b1;
        ld_st     = 5'b01100;
        daddr     = 32'h0000_0300;
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("rstreq mem_req_before", 32'(mem_bus.mem_req), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 32'h9999_9999;
        checkOutput("rstreq mem_req", 32'(mem_bus.mem_req), 32'd0);
        checkOutput("rstreq mem_addr", mem_bus.mem_addr, 32'd0);
        checkOutput("rstreq rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rstreq ready", 32'(req_ready), 32'd1);
        checkOutput("rstreq stall", 32'(stall), 32'd0);
        @(negedge clk);
        mem_bus.mem_ack = 1'b0;
        checkOutput("rstreq late_ack_rsp", 32'(rsp_valid), 32'd0);
        checkOutput("rstreq late_ack_drdata", drdata, 32'd0);
        checkOutput("rstreq late_ack_req", 32'(mem_bus.mem_req), 32'd0);
        last_dr  = 32'h0;
        last_err = 1'b0;

`ifdef DMEM_TIMEOUT_EN
        req_valid = 1'b1;
        ld_st     = 5'b01100;
        daddr     = 32'h0000_0400;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkOutput("tmo mem_req", 32'(mem_bus.mem_req), 32'd1);
            @(negedge clk);
        end
        checkOutput("tmo rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("tmo acc_err", 32'(acc_err), 32'd1);
        checkOutput("tmo drdata", drdata, 32'd0);
        checkOutput("tmo mem_req_drop", 32'(mem_bus.mem_req), 32'd0);
        last_dr  = 32'h0;
        last_err = 1'b1;
        idleCycles(2);
`endif

        for (int n = 0; n < 40; n++) begin
            st = 2'($urandom_range(0, 3));
            ld = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                if ($urandom_range(0, 1) == 1) st = 2'd0;
                else ld = 2'd0;
            end
            t = makeTxn({1'($urandom_range(0, 1)), ld, st}, $urandom, 4'($urandom),
                        $urandom, $urandom_range(0, 3), $urandom);
            applyStimulus(t, $sformatf("rnd%0d", n));
            idleCycles($urandom_range(0, 2));
        end

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
